// File: rtl/beta_pkg.sv
// Shared beta execution-stage types for the multistep shift unit.
//   shu_mode_t     : shift operation encoding (5..7 are illegal)
//   shu_state_t    : shift-unit control states
//   shu_mode_legal : true for the five implemented operations
package beta_pkg;

  typedef enum logic [2:0] {
    SHU_SLL = 3'd0,
    SHU_SRL = 3'd1,
    SHU_SRA = 3'd2,
    SHU_ROL = 3'd3,
    SHU_ROR = 3'd4
  } shu_mode_t;

  typedef enum logic [1:0] {
    SHU_IDLE  = 2'd0,
    SHU_SHIFT = 2'd1,
    SHU_DONE  = 2'd2
  } shu_state_t;

  function automatic logic shu_mode_legal(input logic [2:0] m);
    return m <= 3'd4;
  endfunction

endpackage

// File: rtl/beta_multistep_shift_unit_if.sv
// Request/response bundle for the multistep shift unit.
//   req/gnt           : accept handshake (accepted when req & gnt & !flush)
//   operand_a/_b/mode : data, shift amount, raw 3-bit mode (illegal values allowed)
//   flush             : kill in-flight op, blocks accept
//   busy/valid/result : SHIFT-state flag, one-cycle done pulse, result register
interface beta_multistep_shift_unit_if
  import beta_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int ShamtWidth = $clog2(DataWidth)
);

  logic                  req;
  logic                  gnt;
  logic [DataWidth-1:0]  operand_a;
  logic [ShamtWidth-1:0] operand_b;
  logic [2:0]            mode;
  logic                  flush;
  logic                  busy;
  logic                  valid;
  logic [DataWidth-1:0]  result;

  modport master (
    output req, operand_a, operand_b, mode, flush,
    input  gnt, busy, valid, result
  );

  modport slave (
    input  req, operand_a, operand_b, mode, flush,
    output gnt, busy, valid, result
  );

endinterface

// File: rtl/beta_shift_step.sv
// Combinational single-step shifter: shifts data by step (0..StepBits)
// positions for any shu_mode_t. One barrel stage per bit of step, so a
// step of exactly StepBits uses the top stage alone.
//   data   : operand
//   step   : shift distance, 0..StepBits
//   mode   : operation; illegal encodings pass data through
//   result : shifted data
module beta_shift_step
  import beta_pkg::*;
#(
  parameter  int DataWidth = 32,
  parameter  int StepBits  = 4,
  localparam int StepW     = $clog2(StepBits) + 1
) (
  input  logic [DataWidth-1:0] data,
  input  logic [StepW-1:0]     step,
  input  shu_mode_t            mode,
  output logic [DataWidth-1:0] result
);

  function automatic logic [DataWidth-1:0] shift_by(
    input logic [DataWidth-1:0] x,
    input shu_mode_t            m,
    input int unsigned          amt
  );
    case (m)
      SHU_SLL: return x << amt;
      SHU_SRL: return x >> amt;
      SHU_SRA: return DataWidth'($signed(x) >>> amt);
      // amt == DataWidth degenerates to x | 0, i.e. a full-turn rotate
      SHU_ROL: return (x << amt) | (x >> (DataWidth - amt));
      SHU_ROR: return (x >> amt) | (x << (DataWidth - amt));
      default: return x;
    endcase
  endfunction

  logic [StepW:0][DataWidth-1:0] stage;

  assign stage[0] = data;

  for (genvar i = 0; i < StepW; i++) begin : g_stage
    assign stage[i+1] = step[i] ? shift_by(stage[i], mode, 1 << i) : stage[i];
  end

  assign result = stage[StepW];

endmodule

// File: rtl/beta_multistep_shift_unit.sv
// Multi-cycle shift unit: SLL/SRL/SRA/ROL/ROR by up to StepBits positions
// per cycle. Accept latches the operands; each SHIFT cycle applies one
// step; DONE raises valid for one cycle and can accept the next op.
//   clk_i, rst_i : clock, async active-high reset
//   shu          : slave side of beta_multistep_shift_unit_if
module beta_multistep_shift_unit
  import beta_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int StepBits  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  beta_multistep_shift_unit_if.slave    shu
);

  localparam int ShamtWidth = $clog2(DataWidth);
  localparam int RemW       = ShamtWidth + 1;
  localparam int StepW      = $clog2(StepBits) + 1;

  shu_state_t           state_q, state_d;
  logic [DataWidth-1:0] data_q, result_q, shifted;
  logic [RemW-1:0]      rem_q;
  shu_mode_t            mode_q;
  logic [StepW-1:0]     step;
  logic                 accept, zero_op, last_step;

  assign accept    = shu.req & shu.gnt & ~shu.flush;
  // illegal modes collapse to a zero-length op so operand_a passes through
  assign zero_op   = (shu.operand_b == '0) | ~shu_mode_legal(shu.mode);
  assign step      = (rem_q < RemW'(StepBits)) ? StepW'(rem_q) : StepW'(StepBits);
  assign last_step = (rem_q == RemW'(step));

  beta_shift_step #(
    .DataWidth (DataWidth),
    .StepBits  (StepBits)
  ) u_step (
    .data   (data_q),
    .step   (step),
    .mode   (mode_q),
    .result (shifted)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= SHU_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SHU_IDLE,
      SHU_DONE:  state_d = accept ? (zero_op ? SHU_DONE : SHU_SHIFT) : SHU_IDLE;
      SHU_SHIFT: begin
        if (shu.flush)     state_d = SHU_IDLE;
        else if (last_step) state_d = SHU_DONE;
      end
      default:   state_d = SHU_IDLE;
    endcase
  end

  // gnt is low in SHIFT, so accept and stepping never coincide
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q   <= '0;
      rem_q    <= '0;
      mode_q   <= SHU_SLL;
      result_q <= '0;
    end else if (accept) begin
      data_q <= shu.operand_a;
      rem_q  <= zero_op ? '0 : RemW'(shu.operand_b);
      mode_q <= shu_mode_t'(shu.mode);
      if (zero_op) result_q <= shu.operand_a;
    end else if (state_q == SHU_SHIFT && !shu.flush) begin
      data_q <= shifted;
      rem_q  <= rem_q - RemW'(step);
      if (last_step) result_q <= shifted;
    end
  end

  assign shu.gnt    = (state_q != SHU_SHIFT);
  assign shu.busy   = (state_q == SHU_SHIFT);
  assign shu.valid  = (state_q == SHU_DONE);
  assign shu.result = result_q;

endmodule

// File: tb/tb_beta_multistep_shift_unit.sv
// Self-checking bench for beta_multistep_shift_unit (DataWidth=32, StepBits=4):
// directed table, hand-written handshake/flush/reset sequences, and random
// ops checked against a whole-shift arithmetic reference model.
module tb_beta_multistep_shift_unit;
  import beta_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  beta_multistep_shift_unit_if #(.DataWidth(32)) shu ();

  beta_multistep_shift_unit #(.DataWidth(32), .StepBits(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .shu   (shu)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [31:0] a, input int b, input logic [2:0] m);
    logic [63:0] t;
    case (m)
      3'd0: return a << b;
      3'd1: return a >> b;
      3'd2: return 32'($signed(a) >>> b);
      3'd3: begin t = {a, a} << b; return t[63:32]; end
      3'd4: begin t = {a, a} >> b; return t[31:0]; end
      default: return a;
    endcase
  endfunction

  function automatic int ref_lat(input int b, input logic [2:0] m);
    return (m > 3'd4) ? 0 : (b + 3) / 4;
  endfunction

  // Issue one op from idle; report result and cycles from accept to valid.
  task automatic run_op(input logic [31:0] a, input logic [4:0] b, input logic [2:0] m,
                        output logic [31:0] res, output int lat,
                        output int busy_n, output int gnt_lo);
    @(negedge clk);
    shu.req = 1'b1; shu.operand_a = a; shu.operand_b = b; shu.mode = m;
    @(posedge clk);
    lat = 0; busy_n = 0; gnt_lo = 0;
    @(negedge clk);
    shu.req = 1'b0; shu.operand_a = $urandom; shu.operand_b = 5'($urandom); shu.mode = 3'($urandom);
    while (!shu.valid && lat < 40) begin
      if (shu.busy) busy_n++;
      if (!shu.gnt) gnt_lo++;
      lat++;
      @(negedge clk);
    end
    res = shu.result;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [4:0]  b;
    logic [2:0]  m;
    logic [31:0] exp;
    int          k;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] res;
    int lat, busy_n, gnt_lo, nvalid;
    logic [31:0] a;
    logic [4:0]  b;
    logic [2:0]  m;

    tbl[0] = '{32'h0000_0001, 5'd31, 3'd0, 32'h8000_0000, 8};
    tbl[1] = '{32'h8000_0000, 5'd4,  3'd2, 32'hF800_0000, 1};
    tbl[2] = '{32'hFFFF_FFFF, 5'd7,  3'd1, 32'h01FF_FFFF, 2};
    tbl[3] = '{32'h1234_5678, 5'd8,  3'd4, 32'h7812_3456, 2};
    tbl[4] = '{32'h8000_0001, 5'd1,  3'd3, 32'h0000_0003, 1};
    tbl[5] = '{32'hDEAD_BEEF, 5'd0,  3'd1, 32'hDEAD_BEEF, 0};
    tbl[6] = '{32'h0000_0005, 5'd9,  3'd7, 32'h0000_0005, 0};

    shu.req = 1'b0; shu.flush = 1'b0; shu.operand_a = '0; shu.operand_b = '0; shu.mode = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy",   32'(shu.busy),  32'd0);
    chk("rst_valid",  32'(shu.valid), 32'd0);
    chk("rst_result", shu.result,     32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_gnt", 32'(shu.gnt), 32'd1);

    // directed table
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].m, res, lat, busy_n, gnt_lo);
      chk($sformatf("tbl%0d_result", i), res, tbl[i].exp);
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].k));
      chk($sformatf("tbl%0d_busy", i), 32'(busy_n), 32'(tbl[i].k));
      chk($sformatf("tbl%0d_gnt_low", i), 32'(gnt_lo), 32'(tbl[i].k));
      @(negedge clk);
      chk($sformatf("tbl%0d_pulse", i), 32'(shu.valid), 32'd0);
    end

    // back-to-back: b=0 op, second req held through DONE
    @(negedge clk);
    shu.req = 1'b1; shu.operand_a = 32'hDEAD_BEEF; shu.operand_b = 5'd0; shu.mode = 3'd1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_valid0",  32'(shu.valid), 32'd1);
    chk("b2b_result0", shu.result, 32'hDEAD_BEEF);
    chk("b2b_gnt",     32'(shu.gnt), 32'd1);
    shu.operand_a = 32'h1; shu.operand_b = 5'd4; shu.mode = 3'd0;
    @(posedge clk);
    @(negedge clk);
    shu.req = 1'b0;
    chk("b2b_busy",   32'(shu.busy), 32'd1);
    chk("b2b_valid1", 32'(shu.valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_valid2",  32'(shu.valid), 32'd1);
    chk("b2b_result2", shu.result, 32'h10);

    // flush in DONE blocks the pending accept
    shu.flush = 1'b1; shu.req = 1'b1; shu.operand_a = 32'h77; shu.operand_b = 5'd0; shu.mode = 3'd0;
    @(negedge clk);
    chk("fdone_valid",  32'(shu.valid), 32'd0);
    chk("fdone_busy",   32'(shu.busy),  32'd0);
    chk("fdone_result", shu.result, 32'h10);
    shu.flush = 1'b0; shu.req = 1'b0;

    // flush in the 2nd SHIFT cycle of SLL b=20
    @(negedge clk);
    shu.req = 1'b1; shu.operand_a = 32'h1; shu.operand_b = 5'd20; shu.mode = 3'd0;
    @(posedge clk);
    @(negedge clk);
    shu.req = 1'b0;
    chk("fsh_busy1", 32'(shu.busy), 32'd1);
    @(negedge clk);
    shu.flush = 1'b1; shu.req = 1'b1; shu.operand_a = 32'h99; shu.operand_b = 5'd0;
    chk("fsh_gnt", 32'(shu.gnt), 32'd0);
    @(negedge clk);
    chk("fsh_idle_busy", 32'(shu.busy),  32'd0);
    chk("fsh_no_valid",  32'(shu.valid), 32'd0);
    chk("fsh_result",    shu.result, 32'h10);
    chk("fsh_idle_gnt",  32'(shu.gnt),   32'd1);
    @(negedge clk);
    chk("fidle_valid", 32'(shu.valid), 32'd0);
    chk("fidle_busy",  32'(shu.busy),  32'd0);
    shu.flush = 1'b0; shu.req = 1'b0;
    nvalid = 0;
    repeat (8) begin
      @(negedge clk);
      if (shu.valid) nvalid++;
    end
    chk("fsh_late_valids", 32'(nvalid), 32'd0);

    // async reset in the middle of SHIFT
    @(negedge clk);
    shu.req = 1'b1; shu.operand_a = 32'h3; shu.operand_b = 5'd12; shu.mode = 3'd0;
    @(posedge clk);
    @(negedge clk);
    shu.req = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_busy",   32'(shu.busy),  32'd0);
    chk("mrst_valid",  32'(shu.valid), 32'd0);
    chk("mrst_result", shu.result,     32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_gnt", 32'(shu.gnt), 32'd1);
    run_op(32'h3, 5'd12, 3'd0, res, lat, busy_n, gnt_lo);
    chk("mrst_op_result",  res, 32'h3000);
    chk("mrst_op_latency", 32'(lat), 32'd3);

    // random ops against the reference model
    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      b = 5'($urandom_range(0, 31));
      m = 3'($urandom_range(0, 7));
      run_op(a, b, m, res, lat, busy_n, gnt_lo);
      chk($sformatf("rnd%0d_m%0d_b%0d_result", n, m, b), res, ref_result(a, int'(b), m));
      chk($sformatf("rnd%0d_m%0d_b%0d_latency", n, m, b), 32'(lat), 32'(ref_lat(int'(b), m)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
